address_decoder_multi_channel_param: RTL and testbench
======================================================

Name: address_decoder_multi_channel_param

Overview:
- Parametrised successor to the fixed 12-channel CSR address decoder.
- One Avalon-MM slave port from the management master fans out to NUM_CH Avalon-MM master ports, one per transceiver/MAC channel.
- Adds:
  - a registered request/response FSM;
  - an error response for unmapped channel indices;
  - an optional waitrequest timeout, so one hung channel cannot stall the CSR bus.

Parameters:
- NUM_CH, 12: number of channel ports (1..2**SEL_W).
- SLV_ADDR_W, 20: slave word-address width.
- CH_ADDR_W, 16: per-channel address width. Channel select SEL_W = SLV_ADDR_W-CH_ADDR_W bits, taken from slave_address[SLV_ADDR_W-1:CH_ADDR_W].
- DATA_W, 32: data width.
- ERR_WORD, 32'hDEAD_BEEF: readdata returned on error.
- TIMEOUT_CYC, 1024: waitrequest timeout in cycles (used only with the optional feature).

Ports:
- csr_clk_clk  in  1  CSR clock.
- csr_clk_reset_reset_n  in  1  asynchronous active-low reset.
- slave_address  in  SLV_ADDR_W  slave address.
- slave_read  in  1  read request.
- slave_write  in  1  write request.
- slave_writedata  in  DATA_W  write data.
- slave_readdata  out  DATA_W  read data; valid when slave_waitrequest=0 for a read.
- slave_waitrequest  out  1  stall to master.
- ch_address  out  NUM_CH*CH_ADDR_W  per-channel address, channel i at [i*CH_ADDR_W +: CH_ADDR_W].
- ch_read  out  NUM_CH  per-channel read strobe.
- ch_write  out  NUM_CH  per-channel write strobe.
- ch_writedata  out  NUM_CH*DATA_W  per-channel write data.
- ch_readdata  in  NUM_CH*DATA_W  per-channel read data.
- ch_waitrequest  in  NUM_CH  per-channel stall.
- decode_err  out  1  one-cycle pulse on unmapped access or timeout.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FSM=IDLE; slave_waitrequest=1.
  - slave_readdata=0; ch_read=0, ch_write=0; ch_address=0, ch_writedata=0; decode_err=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: slave_waitrequest=1.
  - On slave_read|slave_write, latch address, writedata, cmd and sel index.
  - If both read and write are high, treat as read.
  - If sel < NUM_CH, go ACCESS. Otherwise set readdata=ERR_WORD, pulse decode_err, go DONE. No channel strobe is issued for an unmapped index.
- ACCESS:
  - Latched address and writedata are broadcast to all channels from registers.
  - Only ch_read[sel] or ch_write[sel] is asserted; all other strobes are 0.
  - When ch_waitrequest[sel]=0: drop strobes, capture ch_readdata[sel] on a read (writes leave readdata unchanged), go DONE.
  - Strobes held stable for the whole of ACCESS.
- DONE:
  - slave_waitrequest=0 for exactly one cycle; slave_readdata stable; return to IDLE.
- Latency:
  - Mapped access: 2 cycles request→IDLE exit, plus channel wait cycles. A zero-wait channel completes with slave_waitrequest low on cycle 3 after the request is presented.
  - Unmapped access: completes in 2 cycles.
- Back-to-back: a new request sampled in the IDLE cycle after DONE is accepted normally. There is no pipelining; one outstanding transaction.
- Slave inputs are ignored outside IDLE; the master must hold its request per Avalon waitrequest rules.
- Reset mid-ACCESS: strobes drop immediately (async), and the transaction is lost.
- NUM_CH=2**SEL_W: the unmapped path is unreachable but stays present.

Optional Feature:
- Macro: ADDR_DECODER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle while ch_waitrequest[sel]=1.
  - On reaching TIMEOUT_CYC-1 it aborts: strobes drop, readdata=ERR_WORD (also for writes), decode_err pulses, go DONE.
  - The counter width is clog2(TIMEOUT_CYC)+1 and the counter saturates.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package address_decoder_pkg holds:
  - the FSM state enum (IDLE/ACCESS/DONE);
  - the default ERR_WORD constant;
  - SEL_W derivation helper;
  - a clog2 function.
- One sub-module, address_decoder_timeout: counter plus expiry compare, instantiated only under ADDR_DECODER_TIMEOUT_EN.

Test Plan:
- Write to 0x3_0010, data 0x1234_5678, all channels zero-wait → ch_write[3] high for 1 cycle with ch_address[3]=0x0010 and writedata 0x1234_5678; no other strobe; slave_waitrequest low on cycle 3.
- Read from 0xB_00FF while ch_waitrequest[11] is held for 5 cycles, readdata 0xCAFE_0011 → ch_read[11] high for 6 cycles; slave_readdata=0xCAFE_0011 with waitrequest low once.
- Read from 0xE_0000 (NUM_CH=12) → no channel strobe; readdata=0xDEAD_BEEF; decode_err pulses once; completes in 2 cycles.
- Timeout (macro on, TIMEOUT_CYC=16), channel 2 waitrequest stuck high → abort after 16 ACCESS cycles; ERR_WORD returned; decode_err pulses. With the macro off, still stalled at cycle 100.
- Reset asserted during ACCESS on channel 5 → ch_read=0 immediately, slave_waitrequest=1; after release, a read to channel 0 completes normally.
- Back-to-back 8 reads cycling through channels 0..7 → each returns its channel's data in order, with no missed or duplicated strobes.

Source files
------------

// File: rtl/address_decoder_pkg.sv
// address_decoder_pkg
// Shared definitions for the multi-channel CSR address decoder:
//   - state_t          : request/response FSM states (IDLE, ACCESS, DONE)
//   - DEFAULT_ERR_WORD : read data returned for unmapped or timed-out accesses
//   - sel_width()      : number of channel-select bits above the channel address
//   - clog2()          : ceiling log2, used to size the timeout counter
package address_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_WORD = 32'hDEAD_BEEF;

    // The channel index lives in the address bits above the per-channel window.
    function automatic int sel_width(input int slv_addr_w, input int ch_addr_w);
        return slv_addr_w - ch_addr_w;
    endfunction

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/address_decoder_timeout.sv
// address_decoder_timeout
// Saturating wait counter used to abort an access to a channel whose
// waitrequest never drops.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : hold the counter at zero (asserted whenever the FSM is not in ACCESS)
//   count_en   : advance the counter (ACCESS cycle with the selected channel stalling)
//   expired    : counter has reached TIMEOUT_CYC-1
module address_decoder_timeout
    import address_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    // Counter saturates so a very long stall can never wrap back below LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/address_decoder_multi_channel_param.sv
// address_decoder_multi_channel_param
// Fans one Avalon-MM CSR slave port out to NUM_CH Avalon-MM channel master
// ports. The upper address bits select the channel; the lower CH_ADDR_W bits
// are forwarded. A registered IDLE -> ACCESS -> DONE FSM handles one
// transaction at a time; unmapped channel indices get ERR_WORD and a
// decode_err pulse without touching any channel.
// Optional feature: define ADDR_DECODER_TIMEOUT_EN to abort accesses whose
// channel holds waitrequest for TIMEOUT_CYC cycles.
// Ports:
//   csr_clk_clk, csr_clk_reset_reset_n : clock, asynchronous active-low reset
//   slave_*                            : Avalon-MM slave from the management master
//   ch_*                               : per-channel Avalon-MM masters (channel i at slice i)
//   decode_err                         : one-cycle pulse on unmapped access or timeout
module address_decoder_multi_channel_param
    import address_decoder_pkg::*;
#(
    parameter int                 NUM_CH      = 12,
    parameter int                 SLV_ADDR_W  = 20,
    parameter int                 CH_ADDR_W   = 16,
    parameter int                 DATA_W      = 32,
    parameter logic [DATA_W-1:0]  ERR_WORD    = DATA_W'(DEFAULT_ERR_WORD),
    parameter int                 TIMEOUT_CYC = 1024
) (
    input  logic                          csr_clk_clk,
    input  logic                          csr_clk_reset_reset_n,
    input  logic [SLV_ADDR_W-1:0]         slave_address,
    input  logic                          slave_read,
    input  logic                          slave_write,
    input  logic [DATA_W-1:0]             slave_writedata,
    output logic [DATA_W-1:0]             slave_readdata,
    output logic                          slave_waitrequest,
    output logic [NUM_CH*CH_ADDR_W-1:0]   ch_address,
    output logic [NUM_CH-1:0]             ch_read,
    output logic [NUM_CH-1:0]             ch_write,
    output logic [NUM_CH*DATA_W-1:0]      ch_writedata,
    input  logic [NUM_CH*DATA_W-1:0]      ch_readdata,
    input  logic [NUM_CH-1:0]             ch_waitrequest,
    output logic                          decode_err
);

    localparam int SEL_W = sel_width(SLV_ADDR_W, CH_ADDR_W);
    localparam logic [SEL_W:0] NUM_CH_LIM = (SEL_W+1)'(NUM_CH);

    state_t                 state;
    logic [CH_ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [SEL_W-1:0]       sel_q;
    logic                   is_read_q;
    logic [NUM_CH-1:0]      rd_strobe_q;
    logic [NUM_CH-1:0]      wr_strobe_q;
    logic                   waitreq_q;
    logic                   err_q;

    logic [SEL_W-1:0]       sel_in;
    logic                   sel_mapped;
    logic [NUM_CH-1:0]      sel_onehot;
    logic                   sel_wait;
    logic [DATA_W-1:0]      sel_rdata;
    logic                   timed_out;

    assign sel_in     = slave_address[SLV_ADDR_W-1:CH_ADDR_W];
    // Extra MSB keeps the compare meaningful when NUM_CH == 2**SEL_W.
    assign sel_mapped = ({1'b0, sel_in} < NUM_CH_LIM);

    // Decode the incoming index to a one-hot strobe and mux back the latched
    // channel's waitrequest/readdata; loops avoid out-of-range part selects.
    always_comb begin
        sel_onehot = '0;
        sel_wait   = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_onehot[i] = (sel_in == SEL_W'(i));
            if (sel_q == SEL_W'(i)) begin
                sel_wait  = ch_waitrequest[i];
                sel_rdata = ch_readdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ADDR_DECODER_TIMEOUT_EN
    logic expired;

    address_decoder_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (csr_clk_clk),
        .rst_n    (csr_clk_reset_reset_n),
        .clear    (state != ACCESS),
        .count_en ((state == ACCESS) && sel_wait),
        .expired  (expired)
    );

    assign timed_out = expired;
`else
    assign timed_out = 1'b0;
`endif

    // Request/response FSM. Every output comes straight from a register so the
    // channel strobes stay glitch-free and stable for the whole of ACCESS.
    always_ff @(posedge csr_clk_clk or negedge csr_clk_reset_reset_n) begin
        if (!csr_clk_reset_reset_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sel_q       <= '0;
            is_read_q   <= 1'b0;
            rd_strobe_q <= '0;
            wr_strobe_q <= '0;
            waitreq_q   <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    waitreq_q <= 1'b1;
                    if (slave_read || slave_write) begin
                        addr_q    <= slave_address[CH_ADDR_W-1:0];
                        wdata_q   <= slave_writedata;
                        is_read_q <= slave_read;
                        sel_q     <= sel_in;
                        if (sel_mapped) begin
                            // Read wins when both commands are presented together.
                            rd_strobe_q <= slave_read ? sel_onehot : '0;
                            wr_strobe_q <= slave_read ? '0 : sel_onehot;
                            state       <= ACCESS;
                        end else begin
                            rdata_q   <= ERR_WORD;
                            err_q     <= 1'b1;
                            waitreq_q <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    if (!sel_wait) begin
                        rd_strobe_q <= '0;
                        wr_strobe_q <= '0;
                        if (is_read_q) begin
                            rdata_q <= sel_rdata;
                        end
                        waitreq_q <= 1'b0;
                        state     <= DONE;
                    end else if (timed_out) begin
                        rd_strobe_q <= '0;
                        wr_strobe_q <= '0;
                        rdata_q     <= ERR_WORD;
                        err_q       <= 1'b1;
                        waitreq_q   <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    waitreq_q <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ch_address        = {NUM_CH{addr_q}};
    assign ch_writedata      = {NUM_CH{wdata_q}};
    assign ch_read           = rd_strobe_q;
    assign ch_write          = wr_strobe_q;
    assign slave_readdata    = rdata_q;
    assign slave_waitrequest = waitreq_q;
    assign decode_err        = err_q;

endmodule

// File: tb/tb_address_decoder_multi_channel_param.sv
// tb_address_decoder_multi_channel_param
// Self-checking bench for address_decoder_multi_channel_param (NUM_CH=12,
// TIMEOUT_CYC=16). Expected results come from model_txn(), which predicts a
// transaction's outcome from the address map, channel wait count and channel
// data. Honours ADDR_DECODER_TIMEOUT_EN to pick the timeout expectations.
module tb_address_decoder_multi_channel_param;

    localparam int NUM_CH     = 12;
    localparam int SLV_ADDR_W = 20;
    localparam int CH_ADDR_W  = 16;
    localparam int DATA_W     = 32;
    localparam int TO_CYC     = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef ADDR_DECODER_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct {
        int          done_cyc;
        int          strobe_cyc;
        int          bad_strobe;
        int          err_cnt;
        int          addr_bad;
        logic [31:0] rdata;
    } obs_t;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [SLV_ADDR_W-1:0]        slave_address;
    logic                         slave_read;
    logic                         slave_write;
    logic [DATA_W-1:0]            slave_writedata;
    logic [DATA_W-1:0]            slave_readdata;
    logic                         slave_waitrequest;
    logic [NUM_CH*CH_ADDR_W-1:0]  ch_address;
    logic [NUM_CH-1:0]            ch_read;
    logic [NUM_CH-1:0]            ch_write;
    logic [NUM_CH*DATA_W-1:0]     ch_writedata;
    logic [NUM_CH*DATA_W-1:0]     ch_readdata;
    logic [NUM_CH-1:0]            ch_waitrequest;
    logic                         decode_err;

    logic [DATA_W-1:0] chan_data [NUM_CH];
    logic [31:0]       model_rdata;
    int                checks   = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_readdata[i*DATA_W +: DATA_W] = chan_data[i];
        end
    end

    address_decoder_multi_channel_param #(
        .NUM_CH      (NUM_CH),
        .SLV_ADDR_W  (SLV_ADDR_W),
        .CH_ADDR_W   (CH_ADDR_W),
        .DATA_W      (DATA_W),
        .ERR_WORD    (ERR),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .csr_clk_clk           (clk),
        .csr_clk_reset_reset_n (rst_n),
        .slave_address         (slave_address),
        .slave_read            (slave_read),
        .slave_write           (slave_write),
        .slave_writedata       (slave_writedata),
        .slave_readdata        (slave_readdata),
        .slave_waitrequest     (slave_waitrequest),
        .ch_address            (ch_address),
        .ch_read               (ch_read),
        .ch_write              (ch_write),
        .ch_writedata          (ch_writedata),
        .ch_readdata           (ch_readdata),
        .ch_waitrequest        (ch_waitrequest),
        .decode_err            (decode_err)
    );

    // Predicted outcome of one transaction. Cycle 1 is the cycle the request
    // is presented; done_cyc is the cycle slave_waitrequest is seen low.
    function automatic obs_t model_txn(input logic [19:0] addr, input logic rd, input int waits);
        obs_t e;
        int   sel;
        e   = '{default: 0};
        sel = int'(addr[19:16]);
        if (sel >= NUM_CH) begin
            e.done_cyc = 2;
            e.err_cnt  = 1;
            e.rdata    = ERR;
        end else if (TIMEOUT_ON && waits >= TO_CYC) begin
            e.strobe_cyc = TO_CYC;
            e.done_cyc   = 2 + TO_CYC;
            e.err_cnt    = 1;
            e.rdata      = ERR;
        end else begin
            e.strobe_cyc = waits + 1;
            e.done_cyc   = 3 + waits;
            e.rdata      = rd ? chan_data[sel] : model_rdata;
        end
        model_rdata = e.rdata;
        return e;
    endfunction

    // Acts as the master plus the addressed channel: presents the request on
    // the next negedge, holds the channel's waitrequest for 'waits' strobe
    // cycles and records what it observes, for at most 'budget' cycles.
    task automatic drive_txn(input logic [19:0] addr, input logic rd, input logic wr,
                             input logic [31:0] wd, input int waits, input int budget,
                             output obs_t o);
        int tgt;
        int nxt;
        int w;
        int cyc;
        o   = '{default: 0};
        tgt = int'(addr[19:16]);
        nxt = (tgt + 1) % NUM_CH;
        w   = waits;
        @(negedge clk);
        slave_address   = addr;
        slave_read      = rd;
        slave_write     = wr;
        slave_writedata = wd;
        ch_waitrequest  = '0;
        cyc = 1;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (decode_err) o.err_cnt++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (i == tgt) begin
                    if (rd ? ch_write[i] : ch_read[i]) o.bad_strobe++;
                end else if (ch_read[i] || ch_write[i]) begin
                    o.bad_strobe++;
                end
            end
            if (tgt < NUM_CH && (rd ? ch_read[tgt] : ch_write[tgt])) begin
                o.strobe_cyc++;
                if (ch_address[tgt*CH_ADDR_W +: CH_ADDR_W] !== addr[15:0]) o.addr_bad++;
                if (ch_address[nxt*CH_ADDR_W +: CH_ADDR_W] !== addr[15:0]) o.addr_bad++;
                if (ch_writedata[tgt*DATA_W +: DATA_W] !== wd) o.addr_bad++;
                ch_waitrequest[tgt] = (w > 0);
                if (w > 0) w--;
            end else begin
                ch_waitrequest = '0;
            end
            if (!slave_waitrequest) begin
                o.done_cyc = cyc;
                o.rdata    = slave_readdata;
                break;
            end
        end
        slave_read     = 1'b0;
        slave_write    = 1'b0;
        ch_waitrequest = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        slave_read     = 1'b0;
        slave_write    = 1'b0;
        ch_waitrequest = '0;
        model_rdata    = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        slave_address   = '0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = '0;
        ch_waitrequest  = '0;
        model_rdata     = '0;
        for (int i = 0; i < NUM_CH; i++) chan_data[i] = $urandom();
        #12;
        checks++; if (slave_waitrequest !== 1'b1) begin failures++; $display("[TB] FAIL rst_waitreq: got %b expected 1", slave_waitrequest); end
        checks++; if (slave_readdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_readdata: got %h expected 0", slave_readdata); end
        checks++; if (ch_read !== '0 || ch_write !== '0) begin failures++; $display("[TB] FAIL rst_strobes: got rd=%h wr=%h expected 0", ch_read, ch_write); end
        checks++; if (ch_address !== '0) begin failures++; $display("[TB] FAIL rst_address: got %h expected 0", ch_address); end
        checks++; if (ch_writedata !== '0) begin failures++; $display("[TB] FAIL rst_writedata: got %h expected 0", ch_writedata); end
        checks++; if (decode_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_decode_err: got %b expected 0", decode_err); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (slave_waitrequest !== 1'b1) begin failures++; $display("[TB] FAIL idle_waitreq: got %b expected 1", slave_waitrequest); end
    endtask

    task automatic test_write_ch3();
        obs_t o, e;
        e = model_txn(20'h3_0010, 1'b0, 0);
        drive_txn(20'h3_0010, 1'b0, 1'b1, 32'h1234_5678, 0, 50, o);
        checks++; if (o.done_cyc !== e.done_cyc) begin failures++; $display("[TB] FAIL wr3_latency: got %0d expected %0d", o.done_cyc, e.done_cyc); end
        checks++; if (o.strobe_cyc !== e.strobe_cyc) begin failures++; $display("[TB] FAIL wr3_strobe_cycles: got %0d expected %0d", o.strobe_cyc, e.strobe_cyc); end
        checks++; if (o.bad_strobe !== 0) begin failures++; $display("[TB] FAIL wr3_other_strobes: got %0d expected 0", o.bad_strobe); end
        checks++; if (o.addr_bad !== 0) begin failures++; $display("[TB] FAIL wr3_addr_data: got %0d bad samples expected 0", o.addr_bad); end
        checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL wr3_readdata_kept: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.err_cnt !== e.err_cnt) begin failures++; $display("[TB] FAIL wr3_decode_err: got %0d expected %0d", o.err_cnt, e.err_cnt); end
    endtask

    task automatic test_read_wait_ch11();
        obs_t o, e;
        chan_data[11] = 32'hCAFE_0011;
        e = model_txn(20'hB_00FF, 1'b1, 5);
        drive_txn(20'hB_00FF, 1'b1, 1'b0, 32'h0, 5, 50, o);
        checks++; if (o.strobe_cyc !== e.strobe_cyc) begin failures++; $display("[TB] FAIL rd11_strobe_cycles: got %0d expected %0d", o.strobe_cyc, e.strobe_cyc); end
        checks++; if (o.done_cyc !== e.done_cyc) begin failures++; $display("[TB] FAIL rd11_latency: got %0d expected %0d", o.done_cyc, e.done_cyc); end
        checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL rd11_readdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.bad_strobe !== 0 || o.addr_bad !== 0) begin failures++; $display("[TB] FAIL rd11_strobe_addr: got bad=%0d addr=%0d expected 0/0", o.bad_strobe, o.addr_bad); end
        @(negedge clk);
        checks++; if (slave_waitrequest !== 1'b1) begin failures++; $display("[TB] FAIL rd11_single_done: got waitreq %b expected 1", slave_waitrequest); end
    endtask

    task automatic test_unmapped();
        obs_t o, e;
        e = model_txn(20'hE_0000, 1'b1, 0);
        drive_txn(20'hE_0000, 1'b1, 1'b0, 32'h0, 0, 50, o);
        checks++; if (o.done_cyc !== e.done_cyc) begin failures++; $display("[TB] FAIL unmap_latency: got %0d expected %0d", o.done_cyc, e.done_cyc); end
        checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL unmap_readdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.bad_strobe !== 0) begin failures++; $display("[TB] FAIL unmap_strobes: got %0d expected 0", o.bad_strobe); end
        checks++; if (o.err_cnt !== e.err_cnt) begin failures++; $display("[TB] FAIL unmap_decode_err: got %0d expected %0d", o.err_cnt, e.err_cnt); end
        @(negedge clk);
        checks++; if (decode_err !== 1'b0) begin failures++; $display("[TB] FAIL unmap_err_pulse_width: got %b expected 0", decode_err); end
    endtask

    task automatic test_timeout();
        obs_t o;
`ifdef ADDR_DECODER_TIMEOUT_EN
        obs_t e;
        e = model_txn(20'h2_0100, 1'b1, 1000);
        drive_txn(20'h2_0100, 1'b1, 1'b0, 32'h0, 1000, 100, o);
        checks++; if (o.strobe_cyc !== e.strobe_cyc) begin failures++; $display("[TB] FAIL to_strobe_cycles: got %0d expected %0d", o.strobe_cyc, e.strobe_cyc); end
        checks++; if (o.done_cyc !== e.done_cyc) begin failures++; $display("[TB] FAIL to_latency: got %0d expected %0d", o.done_cyc, e.done_cyc); end
        checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL to_readdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.err_cnt !== e.err_cnt) begin failures++; $display("[TB] FAIL to_decode_err: got %0d expected %0d", o.err_cnt, e.err_cnt); end
`else
        drive_txn(20'h2_0100, 1'b1, 1'b0, 32'h0, 1000, 100, o);
        checks++; if (o.done_cyc !== 0) begin failures++; $display("[TB] FAIL stall_completed: got done cycle %0d expected still stalled", o.done_cyc); end
        checks++; if (o.strobe_cyc !== 99) begin failures++; $display("[TB] FAIL stall_strobe_cycles: got %0d expected 99", o.strobe_cyc); end
        checks++; if (o.err_cnt !== 0) begin failures++; $display("[TB] FAIL stall_decode_err: got %0d expected 0", o.err_cnt); end
`endif
        apply_reset();
    endtask

    task automatic test_reset_mid_access();
        obs_t o, e;
        @(negedge clk);
        slave_address     = 20'h5_0040;
        slave_read        = 1'b1;
        ch_waitrequest    = '0;
        ch_waitrequest[5] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ch_read[5] !== 1'b1) begin failures++; $display("[TB] FAIL mid_strobe_before: got %b expected 1", ch_read[5]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ch_read !== '0) begin failures++; $display("[TB] FAIL mid_strobe_async_drop: got %h expected 0", ch_read); end
        checks++; if (slave_waitrequest !== 1'b1) begin failures++; $display("[TB] FAIL mid_waitreq: got %b expected 1", slave_waitrequest); end
        slave_read     = 1'b0;
        ch_waitrequest = '0;
        model_rdata    = '0;
        @(negedge clk);
        rst_n = 1'b1;
        e = model_txn(20'h0_0004, 1'b1, 0);
        drive_txn(20'h0_0004, 1'b1, 1'b0, 32'h0, 0, 50, o);
        checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL mid_recover_readdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.done_cyc !== e.done_cyc) begin failures++; $display("[TB] FAIL mid_recover_latency: got %0d expected %0d", o.done_cyc, e.done_cyc); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [19:0] addr;
        for (int i = 0; i < 8; i++) chan_data[i] = $urandom();
        for (int i = 0; i < 8; i++) begin
            addr = {4'(i), 16'(i * 16'h0101)};
            e = model_txn(addr, 1'b1, 0);
            drive_txn(addr, 1'b1, 1'b0, 32'h0, 0, 50, o);
            checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL b2b_readdata ch%0d: got %h expected %h", i, o.rdata, e.rdata); end
            checks++; if (o.strobe_cyc !== 1 || o.bad_strobe !== 0) begin failures++; $display("[TB] FAIL b2b_strobes ch%0d: got %0d/%0d expected 1/0", i, o.strobe_cyc, o.bad_strobe); end
            checks++; if (o.done_cyc !== e.done_cyc) begin failures++; $display("[TB] FAIL b2b_latency ch%0d: got %0d expected %0d", i, o.done_cyc, e.done_cyc); end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic [3:0]  sel;
        logic [15:0] low;
        logic [19:0] addr;
        logic [31:0] wd;
        logic        rd, wr;
        int          mode, waits;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_CH; i++) chan_data[i] = $urandom();
            sel   = 4'($urandom_range(0, 15));
            low   = 16'($urandom());
            addr  = {sel, low};
            wd    = $urandom();
            mode  = $urandom_range(0, 2);
            rd    = (mode != 1);
            wr    = (mode != 0);
            waits = $urandom_range(0, 3);
            e = model_txn(addr, rd, waits);
            drive_txn(addr, rd, wr, wd, waits, 50, o);
            checks++; if (o.rdata !== e.rdata) begin failures++; $display("[TB] FAIL rand_readdata #%0d: got %h expected %h", n, o.rdata, e.rdata); end
            checks++; if (o.done_cyc !== e.done_cyc) begin failures++; $display("[TB] FAIL rand_latency #%0d: got %0d expected %0d", n, o.done_cyc, e.done_cyc); end
            checks++; if (o.strobe_cyc !== e.strobe_cyc || o.bad_strobe !== 0) begin failures++; $display("[TB] FAIL rand_strobes #%0d: got %0d/%0d expected %0d/0", n, o.strobe_cyc, o.bad_strobe, e.strobe_cyc); end
            checks++; if (o.err_cnt !== e.err_cnt || o.addr_bad !== 0) begin failures++; $display("[TB] FAIL rand_err_addr #%0d: got err=%0d addr=%0d expected %0d/0", n, o.err_cnt, o.addr_bad, e.err_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_write_ch3();
        test_read_wait_ch11();
        test_unmapped();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
